dram_arbiter: RTL and testbench
===============================

// Module: dram_arbiter
// PURPOSE
//  Shares the single-port data DRAM driver between two requesters: M0 (CPU load/store) and M1 (trace/debug loader).
//  Accepts req/gnt/rvalid transactions, round-robin arbitrates, registers the winner's command and drives the driver for one cycle.
//  Returns rdata with rvalid to the owner only. Sits between the core/loader ports and the DRAM driver.
// PARAMETERS
//  ADDR_W  18  byte address width (driver word index = addr[ADDR_W-1:2])
//  DATA_W  32  data width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous reset, active-low
//  mN_req       in   1       N=0,1: request; held until mN_gnt
//  mN_we        in   1       N=0,1: 1=store, 0=load
//  mN_addr      in   ADDR_W  N=0,1: byte address
//  mN_wdata     in   DATA_W  N=0,1: store data, LSB-aligned for sb/sh
//  mN_mask      in   2       N=0,1: 00=byte, 01=half, 10=word
//  mN_gnt       out  1       N=0,1: 1-cycle pulse, command accepted
//  mN_rvalid    out  1       N=0,1: 1-cycle pulse, access complete
//  mN_rdata     out  DATA_W  N=0,1: load data, valid with mN_rvalid
//  mN_err       out  1       N=0,1: misalign error, qualified by mN_rvalid (tied 0 when DRAM_ARB_ERR_EN is undefined)
//  dram_addr    out  ADDR_W  driver address
//  dram_wdata   out  DATA_W  driver write data
//  dram_mask    out  2       driver size mask
//  dram_wen     out  1       driver write enable
//  dram_rdata   in   DATA_W  driver read data (combinational, same cycle)
//  busy         out  1       high in ACCESS or RESP
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; cmd regs 0; rr_last=1, so M0 wins the first tie.
//  FSM:
//   IDLE   -> ACCESS when any req is high.
//   ACCESS -> RESP, always.
//   RESP   -> ACCESS when any req is high; otherwise -> IDLE.
//  Arbitrate (in IDLE, or in RESP):
//   - Only one req high: that requester wins.
//   - Both high: the requester != rr_last wins.
//   - At the clock edge: latch winner's we/addr/wdata/mask and owner id; rr_last<=winner.
//  Arbitration only happens in IDLE or RESP. A req rising during ACCESS waits.
//  ACCESS cycle:
//   - mOwner_gnt=1.
//   - dram_addr, dram_wdata and dram_mask come from the cmd regs.
//   - dram_wen = we_q.
//   - rdata_q <= dram_rdata at the edge.
//  Outside ACCESS: dram_wen=0. dram_addr/dram_wdata/dram_mask hold their last values.
//  RESP cycle: mOwner_rvalid=1, mOwner_rdata=rdata_q.
//  The non-owner's gnt and rvalid stay 0; its rdata holds its previous value.
//  Latency:
//   - From IDLE: req@T -> gnt@T+1, rvalid@T+2.
//   - Back-to-back: 1 access per 2 cycles.
//  Store rvalid: issued for stores too; rdata = pre-store word as read.
//  Fairness: with both requesters streaming, grants alternate M0,M1,M0,...
//  Requester drops req before gnt: the command is still latched if it was already arbitrated. No cancel.
//  Reset mid-operation: immediate abort to IDLE, outputs 0. A DRAM write in progress is not guaranteed.
// CONFIGURATION
//  DRAM_ARB_ERR_EN defined:
//   - Misaligned = (mask=01 & addr[0]) | (mask=10 & addr[1:0]!=0) | mask=11.
//   - Misaligned command: ACCESS keeps dram_wen=0, rdata_q<=0.
//   - RESP then gives rvalid with mOwner_err=1.
//  DRAM_ARB_ERR_EN undefined:
//   - No check; the command is forwarded unchanged.
//   - mN_err tied 0.
// TESTING
//  1. Reset: hold rst_n=0 over edges -> all gnt/rvalid/dram_wen/busy=0. Release, no req -> stays IDLE.
//  2. M0 sw addr=0x10 wdata=0xDEADBEEF, then M0 lw 0x10:
//     - store: m0_gnt@+1 with dram_wen=1, dram_addr=0x10, dram_mask=10; m0_rvalid@+2.
//     - load: m0_rdata=0xDEADBEEF.
//  3. M0 and M1 both req lw in the same cycle after reset -> M0 granted first, M1 granted in M0's RESP cycle.
//     Four continuous reqs each -> gnt order M0,M1,M0,M1; m1_gnt/m1_rvalid never asserted for M0 accesses.
//  4. M1 sb addr=0x13 wdata=0xAA over word 0x11223344 at 0x10, then lw 0x10 -> 0xAA223344.
//     m0 outputs unchanged throughout.
//  5. DRAM_ARB_ERR_EN, M0 sh addr=0x21 -> dram_wen stays 0, m0_rvalid=1 with m0_err=1, memory unchanged.
//     Without the macro -> dram_wen=1, m0_err=0.
//  6. rst_n pulsed low during ACCESS -> outputs 0 asynchronously. Next M1 req after release is served from IDLE with 2-cycle latency.

Source files
------------

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
//   Shares the single-port data DRAM driver between two requesters:
//   M0 (CPU load/store) and M1 (trace/debug loader). Requests are
//   round-robin arbitrated in IDLE or RESP. The winner's command is
//   registered, driven to the DRAM driver for one ACCESS cycle, and the
//   read word is returned to the owner in the following RESP cycle.
//   Throughput: one access every two cycles.
//
// Optional feature macro: DRAM_ARB_ERR_EN
//   defined   : misaligned commands are not written. They return
//               rvalid with rdata=0 and mN_err=1.
//   undefined : no check is made, and mN_err is tied to 0.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   mN_req/we/addr/wdata/mask       requester N command (held until gnt)
//   mN_gnt                          1-cycle pulse in the ACCESS cycle
//   mN_rvalid/rdata/err             1-cycle response in the RESP cycle
//   dram_addr/wdata/mask/wen        driver command (wen only in ACCESS)
//   dram_rdata                      driver read data, same cycle
//   busy                            high in ACCESS or RESP
// ---------------------------------------------------------------------------
module dram_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_mask,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_mask,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic [1:0]        dram_mask,
  output logic              dram_wen,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              rr_last;   // requester granted most recently
  logic              owner;     // requester that owns the current access
  logic              mis_q;     // current command is misaligned
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        mask_q;
  logic [1:0]        gnt_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Winner selection and the winner's command.
  logic              any_req;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [1:0]        win_mask;
  logic              win_mis;

  always_comb begin
    // NOTE: every signal gets a value before any conditional logic, so no
    // path can leave one unassigned and infer a latch.
    any_req   = m0_req | m1_req;
    // On a tie, the requester that did not win last time goes next.
    win       = (m0_req & m1_req) ? ~rr_last : m1_req;
    win_we    = win ? m1_we    : m0_we;
    win_addr  = win ? m1_addr  : m0_addr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_mask  = win ? m1_mask  : m0_mask;
    win_mis   = 1'b0;
`ifdef DRAM_ARB_ERR_EN
    win_mis   = ((win_mask == 2'b01) && win_addr[0])
              || ((win_mask == 2'b10) && (win_addr[1:0] != 2'b00))
              || (win_mask == 2'b11);
`endif
  end

`ifdef DRAM_ARB_ERR_EN
  logic [1:0] err_q;
  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // The driver sees the command registers directly. Between accesses they
  // keep the last command, and only dram_wen is forced low.
  assign dram_addr  = addr_q;
  assign dram_wdata = wdata_q;
  assign dram_mask  = mask_q;
  assign m0_gnt     = gnt_q[0];
  assign m1_gnt     = gnt_q[1];
  assign m0_rvalid  = rvalid_q[0];
  assign m1_rvalid  = rvalid_q[1];
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

  // NOTE: all state here uses non-blocking assignments. Every register then
  // sees the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_last  <= 1'b1;        // M0 wins the first tie
      owner    <= 1'b0;
      mis_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      dram_wen <= 1'b0;
      busy     <= 1'b0;
`ifdef DRAM_ARB_ERR_EN
      err_q    <= '0;
`endif
    end else begin
      // Pulse outputs are high for a single cycle only.
      gnt_q    <= '0;
      rvalid_q <= '0;
      dram_wen <= 1'b0;
`ifdef DRAM_ARB_ERR_EN
      err_q    <= '0;
`endif
      unique case (state)
        IDLE, RESP: begin
          // RESP also arbitrates, which gives back-to-back accesses.
          if (any_req) begin
            state        <= ACCESS;
            busy         <= 1'b1;
            owner        <= win;
            rr_last      <= win;
            addr_q       <= win_addr;
            wdata_q      <= win_wdata;
            mask_q       <= win_mask;
            mis_q        <= win_mis;
            gnt_q[win]   <= 1'b1;
            dram_wen     <= win_we & ~win_mis;
          end else begin
            state        <= IDLE;
            busy         <= 1'b0;
          end
        end
        ACCESS: begin
          // Sample the word as read. For stores this is the pre-store word.
          state           <= RESP;
          busy            <= 1'b1;
          rvalid_q[owner] <= 1'b1;
          if (owner) rdata1_q <= mis_q ? '0 : dram_rdata;
          else       rdata0_q <= mis_q ? '0 : dram_rdata;
`ifdef DRAM_ARB_ERR_EN
          err_q[owner]    <= mis_q;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
//   Directed bench for dram_arbiter. A behavioural DRAM driver model sits on
//   the driver port. Each issued command pushes its expected response
//   (owner, rdata, err) onto a scoreboard queue, computed from a reference
//   memory. Responses are popped and compared when rvalid appears. Grant
//   timing, the driver command, and rdata hold for the non-owner are
//   checked directly.
// ---------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [1:0]        m0_mask, m1_mask;
  logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] dram_addr;
  logic [DATA_W-1:0] dram_wdata, dram_rdata;
  logic [1:0]        dram_mask;
  logic              dram_wen, busy;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_mask(m0_mask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_mask(m1_mask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_mask(dram_mask),
    .dram_wen(dram_wen), .dram_rdata(dram_rdata), .busy(busy)
  );

  // Memory write semantics: byte lane addr[1:0], half lane addr[1], word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [ADDR_W-1:0] a,
                                        input logic [31:0] wd,
                                        input logic [1:0] m);
    logic [31:0] r;
    r = old;
    case (m)
      2'b00:   r[{a[1:0], 3'b000} +: 8]  = wd[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16]  = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic is_mis(input logic [ADDR_W-1:0] a, input logic [1:0] m);
    logic r;
    r = ((m == 2'b01) && a[0]) || ((m == 2'b10) && (a[1:0] != 2'b00)) || (m == 2'b11);
`ifndef DRAM_ARB_ERR_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  // DRAM driver model: combinational read, write on the clock edge.
  logic        init_mem;
  logic [31:0] dram_mem [256];
  assign dram_rdata = dram_mem[dram_addr[9:2]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) dram_mem[i] <= {16'hC0DE, 8'h00, i[7:0]};
    end else if (dram_wen) begin
      dram_mem[dram_addr[9:2]] <= merge(dram_mem[dram_addr[9:2]], dram_addr, dram_wdata, dram_mask);
    end
  end

  // Scoreboard and reference memory.
  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [256];
  logic [31:0] m0_prev, m1_prev;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input logic m, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd, input logic [1:0] mk);
    exp_t        e;
    logic        mis;
    logic [31:0] w;
    mis     = is_mis(a, mk);
    w       = ref_mem[a[9:2]];
    e.owner = m;
    e.rdata = mis ? 32'h0 : w;
    e.err   = mis;
    sb.push_back(e);
    if (we && !mis) ref_mem[a[9:2]] = merge(w, a, wd, mk);
  endtask

  task automatic drive(input logic m, input logic rq, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [1:0] mk);
    if (m) begin
      m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = wd; m1_mask = mk;
    end else begin
      m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = wd; m0_mask = mk;
    end
  endtask

  // Advance one cycle, sample 1 time unit after the edge, and score responses.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_spurious", 64'({m1_rvalid, m0_rvalid}), 64'(2'b00));
      end else begin
        e = sb.pop_front();
        check("rv_owner", 64'({m1_rvalid, m0_rvalid}), 64'(e.owner ? 2'b10 : 2'b01));
        check("rv_rdata", 64'(e.owner ? m1_rdata : m0_rdata), 64'(e.rdata));
        check("rv_err", 64'(e.owner ? m1_err : m0_err), 64'(e.err));
      end
    end
    if (!m0_rvalid) check("m0_rdata_hold", 64'(m0_rdata), 64'(m0_prev));
    if (!m1_rvalid) check("m1_rdata_hold", 64'(m1_rdata), 64'(m1_prev));
    m0_prev = m0_rdata;
    m1_prev = m1_rdata;
  endtask

  // Assert reset (asynchronously, mid-cycle), hold it over edges, release.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dram_wen, busy}), 64'(0));
    check("rst_async_data", 64'({m0_rdata, m1_rdata}), 64'(0));
    check("rst_async_addr", 64'(dram_addr), 64'(0));
    m0_prev = '0;
    m1_prev = '0;
    sb.delete();
    repeat (2) tick();
    check("rst_held_ctl", 64'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, dram_wen, busy}), 64'(0));
    rst_n = 1'b1;
  endtask

  // One access from IDLE with exact latency checks: gnt at +1, rvalid at +2.
  task automatic do_single(input string tag, input logic m, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [31:0] wd, input logic [1:0] mk);
    logic mis;
    mis = is_mis(a, mk);
    push_expect(m, we, a, wd, mk);
    drive(m, 1'b1, we, a, wd, mk);
    tick();
    check({tag, "_gnt"}, 64'({m1_gnt, m0_gnt}), 64'(m ? 2'b10 : 2'b01));
    check({tag, "_wen"}, 64'(dram_wen), 64'(we & ~mis));
    check({tag, "_addr"}, 64'(dram_addr), 64'(a));
    check({tag, "_mask"}, 64'(dram_mask), 64'(mk));
    check({tag, "_wdata"}, 64'(dram_wdata), 64'(wd));
    check({tag, "_busy_acc"}, 64'(busy), 64'(1'b1));
    drive(m, 1'b0, we, a, wd, mk);
    tick();
    check({tag, "_rvalid"}, 64'({m1_rvalid, m0_rvalid}), 64'(m ? 2'b10 : 2'b01));
    check({tag, "_busy_resp"}, 64'(busy), 64'(1'b1));
    tick();
    check({tag, "_idle"}, 64'({m1_rvalid, m0_rvalid, m1_gnt, m0_gnt, busy, dram_wen}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0, n1, k;
    drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, '0, '0, 2'b00);
    init_mem = 1'b1;
    m0_prev  = '0;
    m1_prev  = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = {16'hC0DE, 8'h00, i[7:0]};

    // 1. Reset, then idle with no requests.
    apply_reset();
    init_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_no_req", 64'({busy, m0_gnt, m1_gnt, dram_wen}), 64'(0));
    end

    // 2. M0 store word, then load it back.
    do_single("m0_sw", 1'b0, 1'b1, 18'h10, 32'hDEADBEEF, 2'b10);
    do_single("m0_lw", 1'b0, 1'b0, 18'h10, 32'h0, 2'b10);
    check("m0_lw_data", 64'(m0_rdata), 64'(32'hDEADBEEF));

    // 3. Simultaneous streaming loads after reset: M0,M1,M0,M1,...
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      push_expect(1'b0, 1'b0, 18'(32'h10 + 4 * i), 32'h0, 2'b10);
      push_expect(1'b1, 1'b0, 18'(32'h20 + 4 * i), 32'h0, 2'b10);
    end
    drive(1'b0, 1'b1, 1'b0, 18'h10, 32'h0, 2'b10);
    drive(1'b1, 1'b1, 1'b0, 18'h20, 32'h0, 2'b10);
    n0 = 0; n1 = 0; k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      tick();
      if (c == 0) check("stream_first_gnt", 64'({m1_gnt, m0_gnt}), 64'(2'b01));
      if (m0_gnt || m1_gnt) begin
        check("stream_gnt_order", 64'({m1_gnt, m0_gnt}), 64'(k[0] ? 2'b10 : 2'b01));
        if (m0_gnt) begin
          n0++;
          if (n0 < 4) drive(1'b0, 1'b1, 1'b0, 18'(32'h10 + 4 * n0), 32'h0, 2'b10);
          else        m0_req = 1'b0;
        end
        if (m1_gnt) begin
          n1++;
          if (n1 < 4) drive(1'b1, 1'b1, 1'b0, 18'(32'h20 + 4 * n1), 32'h0, 2'b10);
          else        m1_req = 1'b0;
        end
        k++;
      end
    end
    check("stream_grants", 64'(k), 64'(8));
    repeat (4) tick();
    check("stream_drained", 64'(sb.size()), 64'(0));
    check("stream_idle", 64'(busy), 64'(1'b0));

    // 4. M1 word store, byte store into lane 3, then load.
    do_single("m1_sw", 1'b1, 1'b1, 18'h10, 32'h11223344, 2'b10);
    do_single("m1_sb", 1'b1, 1'b1, 18'h13, 32'h000000AA, 2'b00);
    do_single("m1_lw", 1'b1, 1'b0, 18'h10, 32'h0, 2'b10);
    check("m1_sb_merge", 64'(m1_rdata), 64'(32'hAA223344));

    // 5. Misaligned halfword store by M0, then read the word back.
    do_single("m0_sh_mis", 1'b0, 1'b1, 18'h21, 32'h00005555, 2'b01);
    do_single("m0_lw20", 1'b0, 1'b0, 18'h20, 32'h0, 2'b10);
`ifdef DRAM_ARB_ERR_EN
    check("mis_mem_unchanged", 64'(m0_rdata), 64'(32'hC0DE0008));
`else
    check("mis_forwarded", 64'(m0_rdata), 64'(32'hC0DE5555));
`endif

    // 6. Reset during ACCESS, then M1 served from IDLE.
    drive(1'b0, 1'b1, 1'b0, 18'h14, 32'h0, 2'b10);
    tick();
    check("abort_in_access", 64'({m0_gnt, busy}), 64'(2'b11));
    drive(1'b0, 1'b0, 1'b0, 18'h14, 32'h0, 2'b10);
    apply_reset();
    do_single("m1_after_rst", 1'b1, 1'b0, 18'h24, 32'h0, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
